// File: rtl/prg_uploader.sv
// prg_uploader: streams the resident BASIC program (BASTXT..PROGND-1) from RAM onto a valid/ready byte stream.
// Define PRG_UPLOADER_HEADER_EN to prefix the stream with a 2-byte little-endian length header.
module prg_uploader #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [15:0] MAX_LEN    = 16'h7ECC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        rd,
  output logic [24:0] addr,
  input  logic [7:0]  rdata,
  output logic [7:0]  up_data,
  output logic        up_valid,
  input  logic        up_ready,
  output logic        up_last,
  output logic [15:0] up_len,
  output logic        uploading,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] BASTXT    = 16'h8133;
  localparam logic [24:0] PROGND_LO = 25'h81BB;
  localparam logic [24:0] PROGND_HI = 25'h81BC;
  localparam logic [2:0]  LAT       = 3'(RD_LATENCY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CALC,
`ifdef PRG_UPLOADER_HEADER_EN
    S_HDR,
`endif
    S_FETCH,
    S_SEND,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic        last_byte;
`ifdef PRG_UPLOADER_HEADER_EN
  logic        hb_q, hb_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef PRG_UPLOADER_HEADER_EN
      hb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef PRG_UPLOADER_HEADER_EN
      hb_q    <= hb_d;
`endif
    end
  end

  assign last_byte = (idx_q == len_q - 16'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
`ifdef PRG_UPLOADER_HEADER_EN
    hb_d     = hb_q;
`endif
    rd       = 1'b0;
    up_valid = 1'b0;
    up_last  = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_LO;
          cnt_d   = '0;
          addr_d  = PROGND_LO;
          idx_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_RD_LO: begin
        rd    = (cnt_q == '0);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT) begin
          ptr_d[7:0] = rdata;
          cnt_d      = '0;
          addr_d     = PROGND_HI;
          state_d    = S_RD_HI;
        end
      end
      S_RD_HI: begin
        rd    = (cnt_q == '0);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT) begin
          // length is formed here so up_len is already valid during CALC
          ptr_d[15:8] = rdata;
          len_d       = {rdata, ptr_q[7:0]} - BASTXT;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (ptr_q < BASTXT || len_q > MAX_LEN) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
`ifdef PRG_UPLOADER_HEADER_EN
        else begin
          data_d  = len_q[7:0];
          hb_d    = 1'b0;
          state_d = S_HDR;
        end
`else
        else if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          addr_d  = {9'd0, BASTXT + idx_q};
          state_d = S_FETCH;
        end
`endif
      end
`ifdef PRG_UPLOADER_HEADER_EN
      S_HDR: begin
        up_valid = 1'b1;
        up_last  = hb_q && (len_q == '0);
        if (up_ready) begin
          if (!hb_q) begin
            hb_d   = 1'b1;
            data_d = len_q[15:8];
          end else if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            addr_d  = {9'd0, BASTXT + idx_q};
            state_d = S_FETCH;
          end
        end
      end
`endif
      S_FETCH: begin
        rd    = (cnt_q == '0);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT) begin
          data_d  = rdata;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        up_valid = 1'b1;
        up_last  = last_byte;
        if (up_ready) begin
          idx_d = idx_q + 16'd1;
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            addr_d  = {9'd0, BASTXT + idx_d};
            state_d = S_FETCH;
          end
        end
      end
      S_DONE, S_ERR: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uploading = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign addr      = addr_q;
  assign up_data   = data_q;
  assign up_len    = len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prg_uploader.sv
// Directed bench for prg_uploader: a latency-1 instance and a latency-3 / MAX_LEN=4 instance over a shared RAM model.
module tb_prg_uploader;

`ifdef PRG_UPLOADER_HEADER_EN
  localparam int HN = 2;
`else
  localparam int HN = 0;
`endif
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_w[2];
  logic        ready_w[2];
  logic        rd_w[2];
  logic [24:0] addr_w[2];
  logic [7:0]  rdata_w[2];
  logic [7:0]  up_data_w[2];
  logic        up_valid_w[2];
  logic        up_last_w[2];
  logic [15:0] up_len_w[2];
  logic        uploading_w[2];
  logic        done_w[2];
  logic        err_w[2];

  int total = 0;
  int bad   = 0;

  prg_uploader #(.RD_LATENCY(LAT0)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start_w[0]), .rd(rd_w[0]), .addr(addr_w[0]),
    .rdata(rdata_w[0]), .up_data(up_data_w[0]), .up_valid(up_valid_w[0]), .up_ready(ready_w[0]),
    .up_last(up_last_w[0]), .up_len(up_len_w[0]), .uploading(uploading_w[0]), .done(done_w[0]),
    .err(err_w[0])
  );

  prg_uploader #(.RD_LATENCY(LAT1), .MAX_LEN(16'd4)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start_w[1]), .rd(rd_w[1]), .addr(addr_w[1]),
    .rdata(rdata_w[1]), .up_data(up_data_w[1]), .up_valid(up_valid_w[1]), .up_ready(ready_w[1]),
    .up_last(up_last_w[1]), .up_len(up_len_w[1]), .uploading(uploading_w[1]), .done(done_w[1]),
    .err(err_w[1])
  );

  // RAM model: data appears exactly LAT cycles after rd; 0xEE otherwise
  logic [7:0] mem [0:65535];
  logic [7:0] pipe [2][4];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 3; s > 0; s--) pipe[d][s] <= pipe[d][s-1];
      pipe[d][0] <= rd_w[d] ? mem[addr_w[d][15:0]] : 8'hEE;
    end
  end
  assign rdata_w[0] = pipe[0][LAT0-1];
  assign rdata_w[1] = pipe[1][LAT1-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_n[2]     = '{0, 0};
  int rdv_n[2]    = '{0, 0};
  int valid_n[2]  = '{0, 0};
  int stall_n[2]  = '{0, 0};
  int hs_n[2]     = '{0, 0};
  int done_n[2]   = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int hold_bad[2] = '{0, 0};
  int         rd_cyc [2][256];
  int         hs_cyc [2][256];
  logic [7:0] hs_data[2][256];
  logic       hs_last[2][256];
  logic       pv[2];
  logic       pr[2];
  logic [7:0] pdata[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_w[d]) begin
        if (rd_n[d] < 256) rd_cyc[d][rd_n[d]] = cyc;
        rd_n[d]++;
        if (up_valid_w[d]) rdv_n[d]++;
      end
      if (up_valid_w[d]) begin
        valid_n[d]++;
        if (!ready_w[d]) stall_n[d]++;
      end
      if (up_valid_w[d] && ready_w[d]) begin
        if (hs_n[d] < 256) begin
          hs_data[d][hs_n[d]] = up_data_w[d];
          hs_last[d][hs_n[d]] = up_last_w[d];
          hs_cyc[d][hs_n[d]]  = cyc;
        end
        hs_n[d]++;
      end
      if (done_w[d]) begin
        done_n[d]++;
        done_cyc[d] = cyc;
      end
      if (reset_n && pv[d] && !pr[d] && (!up_valid_w[d] || up_data_w[d] !== pdata[d])) hold_bad[d]++;
      pv[d]    = up_valid_w[d] && reset_n;
      pr[d]    = ready_w[d];
      pdata[d] = up_data_w[d];
    end
  end

  function automatic logic [7:0] exp_byte(input int k, input logic [15:0] len, input logic [39:0] prog);
    if (k < HN) return (k == 0) ? len[7:0] : len[15:8];
    return prog[(k-HN)*8 +: 8];
  endfunction

  task automatic set_prog(input logic [15:0] pend, input int n, input logic [39:0] prog);
    mem[16'h81BB] = pend[7:0];
    mem[16'h81BC] = pend[15:8];
    for (int i = 0; i < n; i++) mem[16'h8133 + i] = prog[i*8 +: 8];
  endtask

  // start high for exactly one cycle; returns 1ns into the following cycle
  task automatic kick(input int d);
    @(posedge clk); #1 start_w[d] = 1'b1;
    @(posedge clk); #1 start_w[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int db, output bit to);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_n[d] > db) break;
    end
    to = (done_n[d] <= db);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({rd_w[0], up_valid_w[0], up_last_w[0], uploading_w[0], done_w[0], err_w[0]} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {rd_w[0], up_valid_w[0], up_last_w[0], uploading_w[0], done_w[0], err_w[0]}); end
    total++; if (addr_w[0] !== 25'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr_w[0]); end
    total++; if (up_data_w[0] !== 8'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", up_data_w[0]); end
    total++; if (up_len_w[0] !== 16'h0) begin bad++; $display("FAIL reset_len got=%h exp=0", up_len_w[0]); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [39:0] prog = {8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1};
    int hb = hs_n[0], rb = rd_n[0], db = done_n[0], vb = rdv_n[0];
    bit to;
    set_prog(16'h8136, 3, prog);
    ready_w[0] = 1'b1;
    kick(0);
    total++; if (uploading_w[0] !== 1'b1) begin bad++; $display("FAIL basic_uploading got=%b exp=1", uploading_w[0]); end
    total++; if (rd_w[0] !== 1'b1) begin bad++; $display("FAIL basic_first_rd got=%b exp=1", rd_w[0]); end
    total++; if (addr_w[0] !== 25'h81BB) begin bad++; $display("FAIL basic_first_addr got=%h exp=81bb", addr_w[0]); end
    wait_done(0, db, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
    total++; if (hs_n[0] - hb !== HN + 3) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", hs_n[0] - hb, HN + 3); end
    for (int k = 0; k < HN + 3; k++) begin
      total++; if (hs_data[0][hb+k] !== exp_byte(k, 16'd3, prog) || hs_last[0][hb+k] !== (k == HN + 2)) begin bad++; $display("FAIL basic_byte%0d got=%h/%b exp=%h/%b", k, hs_data[0][hb+k], hs_last[0][hb+k], exp_byte(k, 16'd3, prog), (k == HN + 2)); end
    end
    total++; if (up_len_w[0] !== 16'd3) begin bad++; $display("FAIL basic_len got=%h exp=3", up_len_w[0]); end
    total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err_w[0]); end
    total++; if (done_n[0] - db !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_n[0] - db); end
    total++; if (uploading_w[0] !== 1'b0) begin bad++; $display("FAIL basic_upl_end got=%b exp=0", uploading_w[0]); end
    total++; if (rd_cyc[0][rb+1] - rd_cyc[0][rb] !== LAT0 + 1) begin bad++; $display("FAIL basic_ptr_gap got=%0d exp=%0d", rd_cyc[0][rb+1] - rd_cyc[0][rb], LAT0 + 1); end
    total++; if (hs_cyc[0][hb+HN] - rd_cyc[0][rb+2] !== LAT0 + 1) begin bad++; $display("FAIL basic_rd2valid got=%0d exp=%0d", hs_cyc[0][hb+HN] - rd_cyc[0][rb+2], LAT0 + 1); end
    total++; if (hs_cyc[0][hb+HN+1] - hs_cyc[0][hb+HN] !== LAT0 + 2) begin bad++; $display("FAIL basic_period got=%0d exp=%0d", hs_cyc[0][hb+HN+1] - hs_cyc[0][hb+HN], LAT0 + 2); end
    total++; if (done_cyc[0] - hs_cyc[0][hb+HN+2] !== 1) begin bad++; $display("FAIL basic_done_time got=%0d exp=1", done_cyc[0] - hs_cyc[0][hb+HN+2]); end
    total++; if (rdv_n[0] - vb !== 0) begin bad++; $display("FAIL basic_rd_in_valid got=%0d exp=0", rdv_n[0] - vb); end
  endtask

  task automatic test_stall();
    logic [39:0] prog = {8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1};
    logic [3:0] pat = 4'b1001;
    int hb = hs_n[0], db = done_n[0], vb = rdv_n[0], sb = stall_n[0], xb = hold_bad[0];
    int k = 0;
    set_prog(16'h8136, 3, prog);
    ready_w[0] = 1'b1;
    kick(0);
    for (int i = 0; i < 400 && done_n[0] == db; i++) begin
      @(posedge clk); #1;
      ready_w[0] = pat[3 - (k % 4)];
      k++;
    end
    ready_w[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (done_n[0] - db !== 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", done_n[0] - db); end
    total++; if (hs_n[0] - hb !== HN + 3) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", hs_n[0] - hb, HN + 3); end
    for (int j = 0; j < HN + 3; j++) begin
      total++; if (hs_data[0][hb+j] !== exp_byte(j, 16'd3, prog) || hs_last[0][hb+j] !== (j == HN + 2)) begin bad++; $display("FAIL stall_byte%0d got=%h/%b exp=%h/%b", j, hs_data[0][hb+j], hs_last[0][hb+j], exp_byte(j, 16'd3, prog), (j == HN + 2)); end
    end
    total++; if (!(stall_n[0] - sb > 0)) begin bad++; $display("FAIL stall_seen got=%0d exp=>0", stall_n[0] - sb); end
    total++; if (hold_bad[0] - xb !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", hold_bad[0] - xb); end
    total++; if (rdv_n[0] - vb !== 0) begin bad++; $display("FAIL stall_rd_in_valid got=%0d exp=0", rdv_n[0] - vb); end
  endtask

  task automatic test_empty();
    int hb = hs_n[0], rb = rd_n[0], db = done_n[0], vb = valid_n[0];
    bit to;
    set_prog(16'h8133, 0, 40'h0);
    ready_w[0] = 1'b1;
    kick(0);
    wait_done(0, db, to);
    total++; if (to) begin bad++; $display("FAIL empty_timeout got=no_done exp=done"); end
    total++; if (done_n[0] - db !== 1) begin bad++; $display("FAIL empty_done got=%0d exp=1", done_n[0] - db); end
    total++; if (rd_n[0] - rb !== 2) begin bad++; $display("FAIL empty_rds got=%0d exp=2", rd_n[0] - rb); end
    total++; if (up_len_w[0] !== 16'd0) begin bad++; $display("FAIL empty_len got=%h exp=0", up_len_w[0]); end
    total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL empty_err got=%b exp=0", err_w[0]); end
`ifdef PRG_UPLOADER_HEADER_EN
    total++; if (hs_n[0] - hb !== 2) begin bad++; $display("FAIL empty_count got=%0d exp=2", hs_n[0] - hb); end
    total++; if (hs_data[0][hb] !== 8'h00 || hs_last[0][hb] !== 1'b0) begin bad++; $display("FAIL empty_hdr0 got=%h/%b exp=00/0", hs_data[0][hb], hs_last[0][hb]); end
    total++; if (hs_data[0][hb+1] !== 8'h00 || hs_last[0][hb+1] !== 1'b1) begin bad++; $display("FAIL empty_hdr1 got=%h/%b exp=00/1", hs_data[0][hb+1], hs_last[0][hb+1]); end
`else
    total++; if (hs_n[0] - hb !== 0) begin bad++; $display("FAIL empty_count got=%0d exp=0", hs_n[0] - hb); end
    total++; if (valid_n[0] - vb !== 0) begin bad++; $display("FAIL empty_valid got=%0d exp=0", valid_n[0] - vb); end
    total++; if (done_cyc[0] - rd_cyc[0][rb+1] !== LAT0 + 2) begin bad++; $display("FAIL empty_done_time got=%0d exp=%0d", done_cyc[0] - rd_cyc[0][rb+1], LAT0 + 2); end
`endif
  endtask

  task automatic test_error();
    logic [39:0] prog = {8'h00, 8'h00, 8'h00, 8'h00, 8'hA1};
    int hb = hs_n[0], rb = rd_n[0], db = done_n[0], vb = valid_n[0];
    bit to;
    set_prog(16'h8000, 0, 40'h0);
    ready_w[0] = 1'b1;
    kick(0);
    wait_done(0, db, to);
    total++; if (to) begin bad++; $display("FAIL err_timeout got=no_done exp=done"); end
    total++; if (err_w[0] !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", err_w[0]); end
    total++; if (done_n[0] - db !== 1) begin bad++; $display("FAIL err_done got=%0d exp=1", done_n[0] - db); end
    total++; if (valid_n[0] - vb !== 0) begin bad++; $display("FAIL err_valid got=%0d exp=0", valid_n[0] - vb); end
    total++; if (done_cyc[0] - rd_cyc[0][rb+1] !== LAT0 + 2) begin bad++; $display("FAIL err_done_time got=%0d exp=%0d", done_cyc[0] - rd_cyc[0][rb+1], LAT0 + 2); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (err_w[0] !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_w[0]); end
    hb = hs_n[0]; db = done_n[0];
    set_prog(16'h8134, 1, prog);
    kick(0);
    total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_w[0]); end
    wait_done(0, db, to);
    total++; if (to) begin bad++; $display("FAIL err_retry_timeout got=no_done exp=done"); end
    total++; if (hs_n[0] - hb !== HN + 1) begin bad++; $display("FAIL err_retry_count got=%0d exp=%0d", hs_n[0] - hb, HN + 1); end
    for (int k = 0; k < HN + 1; k++) begin
      total++; if (hs_data[0][hb+k] !== exp_byte(k, 16'd1, prog) || hs_last[0][hb+k] !== (k == HN)) begin bad++; $display("FAIL err_retry_byte%0d got=%h/%b exp=%h/%b", k, hs_data[0][hb+k], hs_last[0][hb+k], exp_byte(k, 16'd1, prog), (k == HN)); end
    end
    total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL err_retry_flag got=%b exp=0", err_w[0]); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] prog = {8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1};
    int hb = hs_n[0], db = done_n[0];
    bit to;
    set_prog(16'h8136, 3, prog);
    ready_w[0] = 1'b1;
    kick(0);
    for (int i = 0; i < 200 && hs_n[0] - hb < HN + 2; i++) begin
      @(posedge clk); #1;
    end
    total++; if (hs_n[0] - hb !== HN + 2) begin bad++; $display("FAIL rmid_reach got=%0d exp=%0d", hs_n[0] - hb, HN + 2); end
    reset_n = 1'b0;
    #1;
    total++; if ({rd_w[0], up_valid_w[0], up_last_w[0], uploading_w[0], done_w[0], err_w[0]} !== 6'b0) begin bad++; $display("FAIL rmid_flags got=%b exp=000000", {rd_w[0], up_valid_w[0], up_last_w[0], uploading_w[0], done_w[0], err_w[0]}); end
    total++; if (addr_w[0] !== 25'h0 || up_data_w[0] !== 8'h0 || up_len_w[0] !== 16'h0) begin bad++; $display("FAIL rmid_regs got=%h/%h/%h exp=0/0/0", addr_w[0], up_data_w[0], up_len_w[0]); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    total++; if (done_n[0] - db !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", done_n[0] - db); end
    hb = hs_n[0]; db = done_n[0];
    kick(0);
    wait_done(0, db, to);
    total++; if (to) begin bad++; $display("FAIL rmid_timeout got=no_done exp=done"); end
    total++; if (hs_n[0] - hb !== HN + 3) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", hs_n[0] - hb, HN + 3); end
    for (int k = 0; k < HN + 3; k++) begin
      total++; if (hs_data[0][hb+k] !== exp_byte(k, 16'd3, prog) || hs_last[0][hb+k] !== (k == HN + 2)) begin bad++; $display("FAIL rmid_byte%0d got=%h/%b exp=%h/%b", k, hs_data[0][hb+k], hs_last[0][hb+k], exp_byte(k, 16'd3, prog), (k == HN + 2)); end
    end
  endtask

  task automatic test_latency3();
    logic [39:0] prog = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    int hb = hs_n[1], rb = rd_n[1], db = done_n[1], vb = valid_n[1];
    bit to;
    set_prog(16'h8137, 4, prog);
    ready_w[1] = 1'b1;
    kick(1);
    total++; if (rd_w[1] !== 1'b1 || addr_w[1] !== 25'h81BB || uploading_w[1] !== 1'b1) begin bad++; $display("FAIL lat3_start got=%b/%h/%b exp=1/81bb/1", rd_w[1], addr_w[1], uploading_w[1]); end
    for (int i = 0; i < 200 && hs_n[1] - hb < HN + 1; i++) begin
      @(posedge clk); #1;
    end
    kick(1);
    wait_done(1, db, to);
    total++; if (to) begin bad++; $display("FAIL lat3_timeout got=no_done exp=done"); end
    total++; if (done_n[1] - db !== 1) begin bad++; $display("FAIL lat3_done got=%0d exp=1", done_n[1] - db); end
    total++; if (rd_n[1] - rb !== 6) begin bad++; $display("FAIL lat3_rds got=%0d exp=6", rd_n[1] - rb); end
    total++; if (rd_cyc[1][rb+1] - rd_cyc[1][rb] !== LAT1 + 1) begin bad++; $display("FAIL lat3_ptr_gap got=%0d exp=%0d", rd_cyc[1][rb+1] - rd_cyc[1][rb], LAT1 + 1); end
    total++; if (hs_n[1] - hb !== HN + 4) begin bad++; $display("FAIL lat3_count got=%0d exp=%0d", hs_n[1] - hb, HN + 4); end
    for (int k = 0; k < HN + 4; k++) begin
      total++; if (hs_data[1][hb+k] !== exp_byte(k, 16'd4, prog) || hs_last[1][hb+k] !== (k == HN + 3)) begin bad++; $display("FAIL lat3_byte%0d got=%h/%b exp=%h/%b", k, hs_data[1][hb+k], hs_last[1][hb+k], exp_byte(k, 16'd4, prog), (k == HN + 3)); end
    end
    for (int k = 0; k < 3; k++) begin
      total++; if (hs_cyc[1][hb+HN+k+1] - hs_cyc[1][hb+HN+k] !== LAT1 + 2) begin bad++; $display("FAIL lat3_period%0d got=%0d exp=%0d", k, hs_cyc[1][hb+HN+k+1] - hs_cyc[1][hb+HN+k], LAT1 + 2); end
    end
    total++; if (up_len_w[1] !== 16'd4 || err_w[1] !== 1'b0) begin bad++; $display("FAIL lat3_len_err got=%h/%b exp=4/0", up_len_w[1], err_w[1]); end
    hb = hs_n[1]; db = done_n[1]; vb = valid_n[1];
    set_prog(16'h8138, 5, prog);
    kick(1);
    wait_done(1, db, to);
    total++; if (to) begin bad++; $display("FAIL maxlen_timeout got=no_done exp=done"); end
    total++; if (err_w[1] !== 1'b1) begin bad++; $display("FAIL maxlen_err got=%b exp=1", err_w[1]); end
    total++; if (valid_n[1] - vb !== 0) begin bad++; $display("FAIL maxlen_valid got=%0d exp=0", valid_n[1] - vb); end
    total++; if (done_n[1] - db !== 1) begin bad++; $display("FAIL maxlen_done got=%0d exp=1", done_n[1] - db); end
  endtask

  initial begin
    reset_n    = 1'b0;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    ready_w[0] = 1'b1;
    ready_w[1] = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h5A;
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_error();
    test_reset_mid();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
